// File: rtl/freq_meter_pkg.sv
// Shared FSM state encoding and fixed timing constants for freq_meter.
package freq_meter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;

  // Cycles spent in ARM so the synchronizer pipeline is full before counting.
  localparam int ARM_CYCLES = 3;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus history flop; rise is a one-cycle pulse per sig edge.
// Latency: rise appears two CLK edges after d goes high; no backpressure.
module sync_rise (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over back-to-back GATE_CYCLES windows, publishing each result.
// Latency: result one edge after the terminal gate cycle; no backpressure (freq_valid is a pulse).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [1:0]       ARM_LAST  = 2'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             w_rise;
  logic             w_term;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  logic [1:0]       r_state;
  logic [1:0]       r_arm_cnt;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;

  sync_rise u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (sig_in),
    .rise  (w_rise)
  );

  // Count including this cycle's rise, so the terminal cycle's edge is not lost.
  assign w_term    = (r_state == ST_GATE) && (r_gate_cnt == GATE_LAST);
  assign w_cnt_sat = (r_edge_cnt == CNT_MAX);
  assign w_cnt_nxt = (w_rise && !w_cnt_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_nxt = r_ovf | (w_rise & w_cnt_sat);
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_arm_cnt  <= '0;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_arm_cnt  <= '0;
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_ovf      <= 1'b0;
          if (en) r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (!en) begin
            r_state   <= ST_IDLE;
            r_arm_cnt <= '0;
          end else if (r_arm_cnt == ARM_LAST) begin
            r_state    <= ST_GATE;
            r_arm_cnt  <= '0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end else begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
          end
        end
        ST_GATE: begin
          if (w_term) begin
            // Publish even if en just dropped; the window completed.
            freq       <= w_cnt_nxt;
            overflow   <= w_ovf_nxt;
            freq_valid <= 1'b1;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_state    <= en ? ST_GATE : ST_IDLE;
          end else if (!en) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            r_edge_cnt <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: directed windows, expected results queued with their publish cycle.
module tb_freq_meter;

  typedef struct {
    int f;
    int o;
    int c;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic       en;
  logic       sig_in;
  logic [7:0] freq;
  logic       freq_valid;
  logic       overflow;
  logic       busy;

  logic       en5;
  logic       sig5;
  logic [4:0] freq5;
  logic       freq_valid5;
  logic       overflow5;
  logic       busy5;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   mode;
  logic lvl;
  logic tog5;
  exp_t q[$];
  exp_t q5[$];

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .en         (en),
    .sig_in     (sig_in),
    .freq       (freq),
    .freq_valid (freq_valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(5)) dut5 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .en         (en5),
    .sig_in     (sig5),
    .freq       (freq5),
    .freq_valid (freq_valid5),
    .overflow   (overflow5),
    .busy       (busy5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input int f, input int o, input int c);
    exp_t e;
    e.f = f;
    e.o = o;
    e.c = c;
    q.push_back(e);
  endtask

  // sig_in: level lvl (mode 0) or toggle every 5 CLK (mode 1).
  initial begin
    sig_in = 1'b0;
    sig5   = 1'b0;
  end

  always @(posedge CLK) begin
    static int tcnt = 0;
    #2;
    if (mode == 1) begin
      if (tcnt == 4) begin
        sig_in = ~sig_in;
        tcnt   = 0;
      end else begin
        tcnt++;
      end
    end else begin
      sig_in = lvl;
      tcnt   = 0;
    end
    if (tog5) sig5 = ~sig5;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && freq_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("freq", int'(freq), e.f);
        chk("overflow", int'(overflow), e.o);
        chk("valid_cycle", cyc, e.c);
      end
    end
    if (RST_N && freq_valid5) begin
      if (q5.size() == 0) begin
        chk("unexpected_valid5", 1, 0);
      end else begin
        e = q5.pop_front();
        chk("freq5", int'(freq5), e.f);
        chk("overflow5", int'(overflow5), e.o);
        chk("valid5_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    exp_t e5;
    n_cmp = 0;
    n_bad = 0;
    mode  = 0;
    lvl   = 1'b0;
    tog5  = 1'b0;
    en    = 1'b0;
    en5   = 1'b0;
    RST_N = 1'b0;

    goto(3);
    chk("rst_freq", int'(freq), 0);
    chk("rst_valid", int'(freq_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    RST_N = 1'b1;

    // Period-10 signal, back-to-back windows; CNT_W=5 instance saturates.
    goto(10);
    mode = 1;
    tog5 = 1'b1;
    en   = 1'b1;
    en5  = 1'b1;
    push(10, 0, 114);
    push(10, 0, 214);
    e5.f = 31;
    e5.o = 1;
    e5.c = 114;
    q5.push_back(e5);
    goto(12);
    chk("busy_arm", int'(busy), 1);
    goto(113);
    en5  = 1'b0;
    tog5 = 1'b0;

    // Abort at gate cycle 50 of the third window.
    goto(264);
    en = 1'b0;
    goto(270);
    chk("abort_freq_hold", int'(freq), 10);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ovf_hold", int'(overflow), 0);

    // Re-arm; drop en during terminal cycle so the result still publishes.
    goto(280);
    en = 1'b1;
    push(10, 0, 384);
    goto(383);
    en = 1'b0;
    goto(386);
    chk("term_en0_busy", int'(busy), 0);

    // Single rise landing on the terminal gate cycle, then static high.
    mode = 0;
    lvl  = 1'b0;
    goto(400);
    en = 1'b1;
    push(1, 0, 504);
    push(0, 0, 604);
    goto(501);
    lvl = 1'b1;
    goto(603);
    en = 1'b0;

    // Static low for two windows.
    goto(610);
    lvl = 1'b0;
    goto(620);
    en = 1'b1;
    push(0, 0, 724);
    push(0, 0, 824);
    goto(823);
    en = 1'b0;

    // Reset pulsed mid-window after a published result.
    goto(830);
    mode = 1;
    en   = 1'b1;
    push(10, 0, 934);
    goto(980);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_freq", int'(freq), 0);
    chk("midrst_valid", int'(freq_valid), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_busy", int'(busy), 0);
    goto(983);
    RST_N = 1'b1;
    push(10, 0, 1087);
    goto(1095);
    en = 1'b0;
    goto(1100);

    chk("pending_q", q.size(), 0);
    chk("pending_q5", q5.size(), 0);
    chk("busy5_idle", int'(busy5), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
